// File: rtl/xalu_pkg.sv
// Shared types and constants for the execute-stage multiply/divide unit.
package xalu_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned DIV_LAT   = 34;
  localparam int unsigned DIV_STEPS = 32;
  localparam int unsigned DIV_CNT_W = 5;

  // Divide-by-zero: quotient is all ones, remainder is the raw dividend.
  localparam logic [XLEN-1:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    XOP_NONE  = 3'd0,
    XOP_MULT  = 3'd1,
    XOP_MULTU = 3'd2,
    XOP_DIV   = 3'd3,
    XOP_DIVU  = 3'd4,
    XOP_MTHI  = 3'd5,
    XOP_MTLO  = 3'd6,
    XOP_MUL   = 3'd7
  } xalu_op_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_MUL_RUN   = 3'd1,
    ST_DIV_SETUP = 3'd2,
    ST_DIV_ITER  = 3'd3,
    ST_DIV_FIX   = 3'd4
  } xalu_state_t;

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
    return n ? XLEN'(~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_iter.sv
// 32-step restoring radix-2 divider on unsigned magnitudes, one quotient bit per step.
module div_iter
  import xalu_pkg::*;
(
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done_c,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  logic [XLEN-1:0]      rem_q, rem_d;
  logic [XLEN-1:0]      quo_q, quo_d;
  logic [XLEN-1:0]      dsr_q, dsr_d;
  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN:0]        rem_sh;
  logic [XLEN-1:0]      diff;

  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    dsr_d  = dsr_q;
    cnt_d  = cnt_q;
    rem_sh = {rem_q, quo_q[XLEN-1]};
    // True difference always fits 32 bits when the subtract is taken.
    diff   = rem_sh[XLEN-1:0] - dsr_q;
    done_c = step && (cnt_q == DIV_CNT_W'(DIV_STEPS - 1));
    if (start) begin
      rem_d = '0;
      quo_d = dividend;
      dsr_d = divisor;
      cnt_d = '0;
    end else if (step) begin
      if (rem_sh >= {1'b0, dsr_q}) begin
        rem_d = diff;
        quo_d = {quo_q[XLEN-2:0], 1'b1};
      end else begin
        rem_d = rem_sh[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], 1'b0};
      end
      cnt_d = DIV_CNT_W'(cnt_q + 1'b1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rem_q <= '0;
      quo_q <= '0;
      dsr_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dsr_q <= dsr_d;
      cnt_q <= cnt_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: owns HI/LO, runs mult/div ops and drives the decode stall.
module mult_div_unit
  import xalu_pkg::*;
#(
  parameter int unsigned MUL_LAT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mul_result,
  output logic        mul_valid
);

  localparam int unsigned MCNT_W = 3;

  xalu_state_t       state_q, state_d;
  logic              busy_q, busy_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [XLEN-1:0]   mul_result_q, mul_result_d;
  logic              mul_valid_q, mul_valid_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [MCNT_W-1:0] mcnt_q, mcnt_d;
  logic              is_mul_q, is_mul_d;
  logic              sgn_q, sgn_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
  logic              qneg_q, qneg_d, rneg_q, rneg_d, div0_q, div0_d;

  xalu_op_t          op_c;
  logic              mul_sgn_c;
  logic [2*XLEN-1:0] ext_a_c, ext_b_c;
  logic              div_start_c, div_step_c, div_done_c;
  logic [XLEN-1:0]   div_quo_c, div_rem_c;

  assign op_c      = xalu_op_t'(op);
  assign mul_sgn_c = (op_c != XOP_MULTU);
  assign ext_a_c   = {{XLEN{mul_sgn_c & src_a[XLEN-1]}}, src_a};
  assign ext_b_c   = {{XLEN{mul_sgn_c & src_b[XLEN-1]}}, src_b};

  div_iter u_div_iter (
    .clk       (clk),
    .resetn    (resetn),
    .start     (div_start_c),
    .step      (div_step_c),
    .dividend  (neg_if(a_q, sgn_q & a_q[XLEN-1])),
    .divisor   (neg_if(b_q, sgn_q & b_q[XLEN-1])),
    .done_c    (div_done_c),
    .quotient  (div_quo_c),
    .remainder (div_rem_c)
  );

  always_comb begin
    state_d      = state_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    mul_result_d = mul_result_q;
    mul_valid_d  = 1'b0;
    prod_d       = prod_q;
    mcnt_d       = mcnt_q;
    is_mul_d     = is_mul_q;
    sgn_d        = sgn_q;
    a_d          = a_q;
    b_d          = b_q;
    qneg_d       = qneg_q;
    rneg_d       = rneg_q;
    div0_d       = div0_q;
    div_start_c  = 1'b0;
    div_step_c   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          unique case (op_c)
            XOP_MTHI: hi_d = src_a;
            XOP_MTLO: lo_d = src_a;
            XOP_MULT, XOP_MULTU, XOP_MUL: begin
              // Only the low 64 bits are kept, so one multiplier serves both signednesses.
              prod_d   = ext_a_c * ext_b_c;
              is_mul_d = (op_c == XOP_MUL);
              mcnt_d   = MCNT_W'(MUL_LAT - 1);
              state_d  = ST_MUL_RUN;
            end
            XOP_DIV, XOP_DIVU: begin
              a_d     = src_a;
              b_d     = src_b;
              sgn_d   = (op_c == XOP_DIV);
              state_d = ST_DIV_SETUP;
            end
            default: ;
          endcase
        end
      end
      ST_MUL_RUN: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (mcnt_q == '0) begin
          if (is_mul_q) begin
            mul_result_d = prod_q[XLEN-1:0];
            mul_valid_d  = 1'b1;
          end else begin
            hi_d = prod_q[2*XLEN-1:XLEN];
            lo_d = prod_q[XLEN-1:0];
          end
          state_d = ST_IDLE;
        end else begin
          mcnt_d = MCNT_W'(mcnt_q - 1'b1);
        end
      end
      ST_DIV_SETUP: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          div_start_c = 1'b1;
          qneg_d      = sgn_q & (a_q[XLEN-1] ^ b_q[XLEN-1]);
          rneg_d      = sgn_q & a_q[XLEN-1];
          div0_d      = (b_q == '0);
          state_d     = ST_DIV_ITER;
        end
      end
      ST_DIV_ITER: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          div_step_c = 1'b1;
          if (div_done_c) state_d = ST_DIV_FIX;
        end
      end
      ST_DIV_FIX: begin
        if (!flush) begin
          if (div0_q) begin
            lo_d = DIV0_QUOTIENT;
            hi_d = a_q;
          end else begin
            lo_d = neg_if(div_quo_c, qneg_q);
            hi_d = neg_if(div_rem_c, rneg_q);
          end
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      hi_q         <= '0;
      lo_q         <= '0;
      mul_result_q <= '0;
      mul_valid_q  <= 1'b0;
      prod_q       <= '0;
      mcnt_q       <= '0;
      is_mul_q     <= 1'b0;
      sgn_q        <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      qneg_q       <= 1'b0;
      rneg_q       <= 1'b0;
      div0_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      mul_result_q <= mul_result_d;
      mul_valid_q  <= mul_valid_d;
      prod_q       <= prod_d;
      mcnt_q       <= mcnt_d;
      is_mul_q     <= is_mul_d;
      sgn_q        <= sgn_d;
      a_q          <= a_d;
      b_q          <= b_d;
      qneg_q       <= qneg_d;
      rneg_q       <= rneg_d;
      div0_q       <= div0_d;
    end
  end

  assign busy       = busy_q;
  assign hi         = hi_q;
  assign lo         = lo_q;
  assign mul_result = mul_result_q;
  assign mul_valid  = mul_valid_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: latencies, HI/LO results, flush and reset behaviour.
module tb_mult_div_unit;
  import xalu_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic [31:0] hi, lo, mul_result;
  logic        mul_valid;

  int passed = 0;
  int total  = 0;

  mult_div_unit #(.MUL_LAT(4)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .op         (op),
    .src_a      (src_a),
    .src_b      (src_b),
    .flush      (flush),
    .busy       (busy),
    .hi         (hi),
    .lo         (lo),
    .mul_result (mul_result),
    .mul_valid  (mul_valid)
  );

  always #5 clk = ~clk;

  // Protocol guard: no start may be issued while the unit is busy.
  always @(posedge clk) begin
    if (resetn && start) begin
      assert (busy === 1'b0) else begin
        total++;
        $error("FAIL start_while_busy: observed busy=%b expected 0", busy);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one start for a single cycle; returns in cycle 1.
  task automatic issue(input xalu_op_t o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    tick();
    start = 1'b0;
    op    = XOP_NONE;
  endtask

  // Counts busy cycles from cycle 1; returns in the first busy=0 cycle.
  task automatic wait_idle(input string tag, input int exp_cycles);
    int n = 0;
    while (busy === 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk(tag, 32'(n), 32'(exp_cycles));
  endtask

  initial begin
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_mul_result", mul_result, 32'd0);
    chk("rst_mul_valid", 32'(mul_valid), 32'd0);
    tick();
    resetn = 1'b1;
    tick();

    issue(XOP_MULT, 32'hFFFF_FFFE, 32'd3);
    chk("mult_busy_c1", 32'(busy), 32'd1);
    wait_idle("mult_lat", 4);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);

    issue(XOP_MULTU, 32'hFFFF_FFFE, 32'd3);
    wait_idle("multu_lat", 4);
    chk("multu_hi", hi, 32'h0000_0002);
    chk("multu_lo", lo, 32'hFFFF_FFFA);

    issue(XOP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle("div_lat", 34);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    issue(XOP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle("divu_lat", 34);
    chk("divu_lo", lo, 32'h0000_0000);
    chk("divu_hi", hi, 32'h8000_0000);

    issue(XOP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle("div_ovf_lat", 34);
    chk("div_ovf_lo", lo, 32'h8000_0000);
    chk("div_ovf_hi", hi, 32'h0000_0000);

    issue(XOP_DIVU, 32'd5, 32'd0);
    wait_idle("divu0_lat", 34);
    chk("divu0_lo", lo, 32'hFFFF_FFFF);
    chk("divu0_hi", hi, 32'd5);

    issue(XOP_DIV, 32'hFFFF_FFF7, 32'd0);
    wait_idle("div0_lat", 34);
    chk("div0_lo", lo, 32'hFFFF_FFFF);
    chk("div0_hi", hi, 32'hFFFF_FFF7);

    issue(XOP_DIV, 32'd100, 32'hFFFF_FFF9);
    wait_idle("div_pos_neg_lat", 34);
    chk("div_pos_neg_lo", lo, 32'hFFFF_FFF2);
    chk("div_pos_neg_hi", hi, 32'd2);

    issue(XOP_MTHI, 32'h0000_1234, 32'd0);
    chk("mthi_hi", hi, 32'h0000_1234);
    chk("mthi_busy", 32'(busy), 32'd0);
    issue(XOP_MTLO, 32'h0000_5678, 32'd0);
    chk("mtlo_lo", lo, 32'h0000_5678);
    chk("mtlo_hi_kept", hi, 32'h0000_1234);
    chk("mtlo_busy", 32'(busy), 32'd0);

    issue(XOP_MUL, 32'd6, 32'd7);
    wait_idle("mul_lat", 4);
    chk("mul_valid", 32'(mul_valid), 32'd1);
    chk("mul_result", mul_result, 32'd42);
    chk("mul_hi_kept", hi, 32'h0000_1234);
    chk("mul_lo_kept", lo, 32'h0000_5678);
    tick();
    chk("mul_valid_pulse", 32'(mul_valid), 32'd0);

    issue(XOP_MUL, 32'hFFFF_FFFD, 32'd5);
    wait_idle("mul_neg_lat", 4);
    chk("mul_neg_result", mul_result, 32'hFFFF_FFF1);
    chk("mul_neg_valid", 32'(mul_valid), 32'd1);

    // Abort a divide in cycle 10.
    issue(XOP_DIV, 32'd100, 32'd7);
    repeat (9) tick();
    chk("abort_busy_c10", 32'(busy), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("abort_busy_c11", 32'(busy), 32'd0);
    repeat (40) tick();
    chk("abort_hi", hi, 32'h0000_1234);
    chk("abort_lo", lo, 32'h0000_5678);

    start = 1'b1; op = XOP_MTLO; src_a = 32'hDEAD_BEEF; flush = 1'b1;
    tick();
    start = 1'b0; op = XOP_NONE; flush = 1'b0;
    chk("flush_mtlo_lo", lo, 32'h0000_5678);

    start = 1'b1; op = XOP_MULT; src_a = 32'd3; src_b = 32'd3; flush = 1'b1;
    tick();
    start = 1'b0; op = XOP_NONE; flush = 1'b0;
    chk("flush_mult_busy", 32'(busy), 32'd0);

    // Flush in the last busy cycle wins over the commit.
    issue(XOP_MULT, 32'd2, 32'd2);
    repeat (3) tick();
    chk("lastcyc_busy", 32'(busy), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("lastcyc_busy_after", 32'(busy), 32'd0);
    chk("lastcyc_hi", hi, 32'h0000_1234);
    chk("lastcyc_lo", lo, 32'h0000_5678);

    issue(XOP_DIV, 32'd1000, 32'd3);
    repeat (5) tick();
    #2;
    resetn = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    tick();
    resetn = 1'b1;
    tick();
    issue(XOP_MULT, 32'd7, 32'd8);
    wait_idle("postrst_lat", 4);
    chk("postrst_hi", hi, 32'd0);
    chk("postrst_lo", lo, 32'd56);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit (XALU) in the execute stage of the 5-stage MIPS core. Owns the architectural HI/LO registers, executes mult/multu/div/divu/mthi/mtlo/mul, and drives the `busy` signal that the stall control unit combines with the MultFamily decode to hold the decode stage. Operands arrive from the E-stage forwarding muxes; HI/LO are read by mfhi/mflo in E, and `mul` results go to the E/M writeback path.

## Interface
- `MUL_LAT`, default 4: cycles `busy` stays high for mult/multu/mul, range 1..8.
- `DIV_LAT`, fixed 34: cycles `busy` stays high for div/divu. 1 setup + 32 iterations + 1 fixup; not overridable.
- `clk`  in  1  core clock.
- `resetn`  in  1  asynchronous active-low reset.
- `start`  in  1  valid XALU op in E this cycle.
- `op`  in  3  xalu_op_t: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MUL=7.
- `src_a`  in  32  rs value, or dividend.
- `src_b`  in  32  rt value, or divisor.
- `flush`  in  1  squash of the instruction that owns the current or starting op.
- `busy`  out  1  registered; operation in flight.
- `hi`, `lo`  out  32  architectural HI/LO, registered.
- `mul_result`  out  32  low 32 bits of the signed product for MUL.
- `mul_valid`  out  1  one-cycle pulse with `mul_result`.

## Operation
- Reset: `busy`=0, `hi`=`lo`=0, `mul_result`=0, `mul_valid`=0, state IDLE.
- States: IDLE, MUL_RUN, DIV_SETUP, DIV_ITER, DIV_FIX.
- A start is accepted only in IDLE with `flush`=0. A start while busy is a protocol violation: it is ignored, and the bench asserts it never occurs.
- MTHI/MTLO: write `hi`/`lo` with `src_a` at the start edge. `busy` does not assert.
- MULT/MULTU: 64-bit signed/unsigned product. Go to MUL_RUN, where a down-counter loads MUL_LAT-1. At counter==0, commit {hi,lo}=product and return to IDLE.
- MUL: same path. Signed product; at completion the low word goes to `mul_result` with `mul_valid` for one cycle. HI/LO are unchanged.
- DIV/DIVU:
  - DIV_SETUP latches |a|, |b| (signed) or raw values (unsigned), plus the quotient and remainder signs.
  - DIV_ITER runs 32 restoring radix-2 steps, one bit per cycle, with a 5-bit counter.
  - DIV_FIX negates as needed, commits lo=quotient, hi=remainder, and returns to IDLE.
  - Remainder sign follows the dividend. 0x80000000 / -1 gives lo=0x80000000, hi=0.
- Divide by zero: full latency is still taken. Result is lo=0xFFFFFFFF, hi=src_a.
- `flush` while busy: abort. The state goes to IDLE at the next edge, with no HI/LO commit and no `mul_valid`. `flush` with `start` in the same cycle: the start is cancelled, including for MTHI/MTLO.
- Simultaneous completion and `flush` in the same cycle: the flush wins and there is no commit.

## Timing
- Start edge is cycle 0. Commit and `busy` fall together at the end of the last busy cycle.
- MULT/MULTU/MUL: `busy` is high in cycles 1..MUL_LAT. New `hi`/`lo` are visible in cycle MUL_LAT+1 with `busy`=0. `mul_valid` is high in cycle MUL_LAT+1.
- DIV/DIVU: `busy` is high in cycles 1..34, and the result is visible in cycle 35.
- MTHI/MTLO: the new value is visible in cycle 1.
- Back-to-back: a new start is accepted in the first cycle `busy`=0, and its result commits without a bubble.
- `busy` is purely registered, with no combinational path from `start`. The E-stage-resident case is covered by the stall unit's D_MultCalFamily term.
- Reset mid-operation: outputs return to reset values immediately (asynchronous).

## Structure
- Shared package `xalu_pkg` holds:
  - the `xalu_op_t` enum;
  - `DIV_LAT` = 34;
  - the division-by-zero result constants.
- Decode to `xalu_op_t` lives in the existing decoder, not here.
- Sub-module `div_iter`: holds the 32-step restoring divider datapath, with start/step/done and unsigned magnitudes in and out. Sign handling and the FSM stay in `mult_div_unit`.
- The multiplier is a behavioural `*` with a MUL_LAT-deep counter. Retiming is left to synthesis.

## Test plan
- MULT: a=0xFFFFFFFE (-2), b=3 → `busy` high for 4 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. Same operands with MULTU → hi=0x00000002, lo=0xFFFFFFFA.
- DIV: a=-7, b=2 → `busy` high for 34 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU with a=0x80000000, b=0xFFFFFFFF → lo=0, hi=0x80000000.
- DIV a=0x80000000, b=-1 → lo=0x80000000, hi=0. DIVU a=5, b=0 → lo=0xFFFFFFFF, hi=5 after 34 cycles.
- MTHI 0x1234 then MTLO 0x5678 on consecutive cycles → hi=0x1234 in cycle 1, lo=0x5678 in cycle 2, `busy` stays 0. MUL 6×7 → `mul_result`=42 with a `mul_valid` pulse, HI/LO unchanged.
- Abort: start DIV, then `flush` in cycle 10 → `busy`=0 in cycle 11, HI/LO unchanged. `start` and `flush` together on MTLO → lo unchanged.
- `resetn` low mid-DIV → `busy`, `hi`, `lo` all go to 0 immediately. A MULT issued after release behaves normally.
